// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int INSN_W = 32;
  localparam logic [INSN_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, BUF, DROP} fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0]       pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// One-entry skid buffer holding a response that arrived while the output was stalled.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         Clock,
  input  logic         nReset,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t in_ent,
  output fetch_entry_t out_ent,
  output logic         valid
);

  // Clear wins over load so a redirect can never leave a stale entry behind.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      valid   <= 1'b0;
      out_ent <= '0;
    end else if (clear) begin
      valid   <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      out_ent <= in_ent;
    end else if (unload) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requests, one-entry buffer, redirect handling.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              hold,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [31:0]       PC,
  output logic [INSN_W-1:0] instruction,
  output logic              fetch_valid
);

  fetch_state_e state, state_nxt;
  logic [31:0]  fetch_pc;
  logic         out_free, rsp_take, rsp_to_out, buf_load, buf_unload;
  logic         buf_valid;
  fetch_entry_t buf_in, buf_out;

  // In WAIT, fetch_pc is still the address that was issued, so it doubles as the response PC.
  assign out_free   = !fetch_valid || !hold;
  assign rsp_take   = (state == WAIT) && imem_rvalid && !redirect;
  assign rsp_to_out = rsp_take && out_free;
  assign buf_load   = rsp_take && !out_free;
  assign buf_unload = (state == BUF) && !hold && buf_valid && !redirect;
  assign buf_in     = '{pc: fetch_pc, insn: imem_rdata};

  assign imem_req  = (state == REQ);
  assign imem_addr = imem_req ? fetch_pc : 32'h0;

  fetch_buf u_buf (
    .Clock   (Clock),
    .nReset  (nReset),
    .load    (buf_load),
    .unload  (buf_unload),
    .clear   (redirect),
    .in_ent  (buf_in),
    .out_ent (buf_out),
    .valid   (buf_valid)
  );

  // State register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; redirect takes priority in every state.
  // A redirect that coincides with the pending response discards it on the spot,
  // so there is nothing left to drop and the FSM returns straight to REQ.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_gnt) state_nxt = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (redirect)         state_nxt = imem_rvalid ? REQ : DROP;
        else if (imem_rvalid) state_nxt = out_free ? REQ : BUF;
      end
      BUF: begin
        if (redirect || !hold) state_nxt = REQ;
      end
      DROP: begin
        if (imem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch address: redirect target (word aligned) or advance after each accepted response.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)       fetch_pc <= RESET_VECTOR;
    else if (redirect) fetch_pc <= {redirect_pc[31:2], 2'b00};
    else if (rsp_take) fetch_pc <= fetch_pc + 32'd4;
  end

  // Output register: flush on redirect, refill from imem or buffer, else drain when consumed.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      PC          <= 32'h0;
      instruction <= NOP;
      fetch_valid <= 1'b0;
    end else if (redirect) begin
      instruction <= NOP;
      fetch_valid <= 1'b0;
    end else if (rsp_to_out) begin
      PC          <= fetch_pc;
      instruction <= imem_rdata;
      fetch_valid <= 1'b1;
    end else if (buf_unload) begin
      PC          <= buf_out.pc;
      instruction <= buf_out.insn;
      fetch_valid <= 1'b1;
    end else if (fetch_valid && !hold) begin
      instruction <= NOP;
      fetch_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/buffer, redirect, wrap and async reset.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        Clock = 1'b0;
  logic        nReset, hold, redirect, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, fetch_valid;
  logic [31:0] imem_addr, PC, instruction;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .hold        (hold),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PC          (PC),
    .instruction (instruction),
    .fetch_valid (fetch_valid)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req},    32'h0);
    chk({tag, "_addr"},  imem_addr,            32'h0);
    chk({tag, "_pc"},    PC,                   32'h0);
    chk({tag, "_insn"},  instruction,          NOP);
    chk({tag, "_valid"}, {31'b0, fetch_valid}, 32'h0);
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    #4;
    chk_rst("rst");
    nReset = 1'b1;
  endtask

  initial begin
    nReset = 1'b0; hold = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // ---- power-on reset ----
    tick(); tick();
    chk_rst("por");
    nReset = 1'b1;

    // ---- streaming: addresses 0,4,8; outputs one cycle after rvalid ----
    tick();                                         // IDLE -> REQ
    chk("s_req0", {31'b0, imem_req}, 32'h1);
    chk("s_addr0", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    tick();                                         // -> WAIT
    chk("s_wait_req", {31'b0, imem_req}, 32'h0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000;
    tick();                                         // response -> outputs
    chk("s_pc0", PC, 32'h0);
    chk("s_insn0", instruction, 32'hA000_0000);
    chk("s_valid0", {31'b0, fetch_valid}, 32'h1);
    chk("s_addr4", imem_addr, 32'h4);
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    tick();                                         // consumed, nothing new
    chk("s_drain_valid", {31'b0, fetch_valid}, 32'h0);
    chk("s_drain_insn", instruction, NOP);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0004;
    tick();
    chk("s_pc4", PC, 32'h4);
    chk("s_insn4", instruction, 32'hA000_0004);
    chk("s_addr8", imem_addr, 32'h8);
    imem_rvalid = 1'b0;

    // ---- hold across two responses: second goes to buffer ----
    tick();
    do_reset();
    tick();                                         // REQ addr 0
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hB000_0000;
    tick();                                         // outputs PC=0, REQ addr 4
    chk("h_pc0", PC, 32'h0);
    hold = 1'b1; imem_rvalid = 1'b0; imem_gnt = 1'b1;
    tick();                                         // -> WAIT, outputs held
    chk("h_hold_pc", PC, 32'h0);
    chk("h_hold_insn", instruction, 32'hB000_0000);
    chk("h_hold_valid", {31'b0, fetch_valid}, 32'h1);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hB000_0004;
    tick();                                         // second response buffered
    chk("h_buf_req", {31'b0, imem_req}, 32'h0);
    chk("h_buf_pc", PC, 32'h0);
    chk("h_buf_insn", instruction, 32'hB000_0000);
    imem_rvalid = 1'b0;
    tick();                                         // still held in BUF
    chk("h_buf_req2", {31'b0, imem_req}, 32'h0);
    hold = 1'b0;
    tick();                                         // buffer -> outputs
    chk("h_unbuf_pc", PC, 32'h4);
    chk("h_unbuf_insn", instruction, 32'hB000_0004);
    chk("h_unbuf_valid", {31'b0, fetch_valid}, 32'h1);
    chk("h_resume_req", {31'b0, imem_req}, 32'h1);
    chk("h_resume_addr", imem_addr, 32'h8);

    // ---- redirect to 0x103 while in WAIT ----
    imem_gnt = 1'b1;
    tick();                                         // -> WAIT (addr 8)
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();                                         // -> DROP
    chk("r_valid", {31'b0, fetch_valid}, 32'h0);
    chk("r_drop_req", {31'b0, imem_req}, 32'h0);
    redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();                                         // stale response discarded
    chk("r_stale_valid", {31'b0, fetch_valid}, 32'h0);
    chk("r_stale_insn", instruction, NOP);
    chk("r_new_req", {31'b0, imem_req}, 32'h1);
    chk("r_new_addr", imem_addr, 32'h0000_0100);
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    tick();
    chk("r_wait_valid", {31'b0, fetch_valid}, 32'h0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC000_0100;
    tick();
    chk("r_pc", PC, 32'h0000_0100);
    chk("r_insn", instruction, 32'hC000_0100);
    chk("r_valid1", {31'b0, fetch_valid}, 32'h1);

    // ---- redirect with hold and valid output; target at top of memory ----
    imem_rvalid = 1'b0; hold = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("rh_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rh_insn", instruction, NOP);
    chk("rh_addr", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0; hold = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hE000_0000;
    tick();
    chk("w_pc", PC, 32'hFFFF_FFFC);
    chk("w_wrap_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b0;

    // ---- async reset in the middle of WAIT, then a late response ----
    imem_gnt = 1'b1;
    tick();                                         // -> WAIT
    imem_gnt = 1'b0;
    #2;
    nReset = 1'b0;
    #1;
    chk_rst("mid");
    #2;
    nReset = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    tick();                                         // IDLE -> REQ, late rvalid ignored
    chk("late_valid", {31'b0, fetch_valid}, 32'h0);
    chk("late_pc", PC, 32'h0);
    chk("late_req", {31'b0, imem_req}, 32'h1);
    tick();                                         // rvalid in REQ ignored
    chk("late_valid2", {31'b0, fetch_valid}, 32'h0);
    chk("late_insn", instruction, NOP);
    imem_rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports: Clock  in  1  clock, all state updates on rising edge.
REQ-003 SHALL have port nReset  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port hold  in  1  downstream stall; the current output is not consumed.
REQ-005 SHALL have port redirect  in  1  taken branch/jump; highest priority.
REQ-006 SHALL have port redirect_pc  in  32  new fetch target.
REQ-007 SHALL have ports imem_req  out  1, imem_addr  out  32, imem_gnt  in  1, imem_rvalid  in  1, imem_rdata  in  32, forming the instruction-memory request/response interface.
REQ-008 SHALL have ports PC  out  32, instruction  out  32, fetch_valid  out  1, forming the fetched-instruction output to the IF stage.

Function
REQ-009 SHALL keep at most one outstanding imem request.
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT, BUF, DROP.
REQ-011 IDLE: the FSM SHALL hold for one cycle after reset, then go to REQ.
REQ-012 REQ: SHALL drive imem_req=1 and imem_addr=fetch_pc; on imem_gnt go to WAIT; the address SHALL stay stable until gnt unless redirect occurs.
REQ-013 WAIT, imem_rvalid, output free (fetch_valid=0 or hold=0): SHALL register PC<=issued addr, instruction<=imem_rdata, fetch_valid<=1, fetch_pc<=fetch_pc+4, then go to REQ.
REQ-014 WAIT, imem_rvalid, fetch_valid=1 and hold=1: SHALL capture the response into the one-entry buffer, advance fetch_pc by 4, and go to BUF.
REQ-015 BUF: SHALL keep imem_req=0; on the first cycle with hold=0, move the buffer contents to the outputs with fetch_valid=1, then go to REQ.
REQ-016 Output consumption: the output SHALL be consumed on any cycle with fetch_valid=1 and hold=0; with no replacement data, fetch_valid SHALL drop to 0 and instruction SHALL go to NOP (32'h0000_0013) on the next edge.
REQ-017 With hold=1, PC, instruction and fetch_valid SHALL remain unchanged.
REQ-018 Redirect, any state: SHALL set fetch_pc<=redirect_pc with bits[1:0] forced to 0, fetch_valid<=0, instruction<=NOP, and invalidate the buffer.
REQ-019 Redirect in WAIT, or in REQ with imem_gnt in the same cycle: SHALL go to DROP; in DROP the next imem_rvalid SHALL be discarded and the FSM SHALL go to REQ.
REQ-020 Redirect in REQ without gnt, or in IDLE/BUF: SHALL go to REQ, driving the new address on the next cycle.
REQ-021 Redirect in DROP: SHALL update fetch_pc and remain in DROP.
REQ-022 Redirect SHALL override hold in the same cycle.
REQ-023 fetch_pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 SHALL wrap to 0.
REQ-024 imem_rvalid outside WAIT/DROP SHALL be ignored.

Reset
REQ-025 On nReset low, SHALL immediately set: state=IDLE, fetch_pc=RESET_VECTOR, imem_req=0, imem_addr=0, PC=0, instruction=NOP, fetch_valid=0, buffer invalid.
REQ-026 Reset asserted during WAIT SHALL abandon the outstanding request; a late rvalid SHALL be ignored per REQ-024.

Structure
REQ-027 Package fetch_pkg SHALL hold the FSM state enum, the NOP constant and the instruction width constant.
REQ-028 The one-entry buffer SHALL be a sub-module fetch_buf (data+PC+valid, load/unload/clear).

Verification
REQ-029 After reset release with gnt=1 and rvalid one cycle later: imem_addr 0,4,8 in sequence; PC/instruction follow each rvalid with one-cycle latency.
REQ-030 hold=1 over two responses: the first stays on the outputs, the second goes to the buffer, imem_req=0; after hold drops, the buffered PC=4 appears, then the fetch resumes at 8.
REQ-031 redirect to 32'h0000_0103 while in WAIT: the stale rvalid is discarded, the next imem_addr=32'h0000_0100, and fetch_valid=0 until the new data arrives.
REQ-032 redirect and hold asserted together with fetch_valid=1: on the next edge fetch_valid=0 and instruction=NOP.
REQ-033 fetch_pc=32'hFFFF_FFFC: the following request address is 0.
REQ-034 nReset pulsed low mid-WAIT: all outputs take their reset values immediately; a late rvalid produces no output.
